// File: rtl/note_display_sequencer_if.sv
// Purpose : bundles the control, note-ROM and LED-decoder signals of the note display sequencer.
// Latency : none, wires only.
// Backpressure: none; pause is a level that freezes playback inside the sequencer.
// Ports   : start/stop pulses and the pause level come in; rom_addr goes out and rom_data comes back
//           one cycle later; code, playing, beat and done are the status and display outputs.
//           master = sequencer side, slave = environment side (controller, ROM, decoder).
interface note_display_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              pause;
    logic              stop;
    logic [ADDR_W-1:0] rom_addr;
    logic [5:0]        rom_data;
    logic [3:0]        code;
    logic              playing;
    logic              beat;
    logic              done;

    modport master (
        input  start, pause, stop, rom_data,
        output rom_addr, code, playing, beat, done
    );

    modport slave (
        output start, pause, stop, rom_data,
        input  rom_addr, code, playing, beat, done
    );
endinterface

// File: rtl/note_display_sequencer.sv
// Purpose : walks a melody in a synchronous note ROM, holds each note code for its beat count
//           and blanks the display for a short gap between notes.
// Latency : start sampled at edge n gives the first note code on the display from edge n+2.
// Backpressure: none; pause (level) freezes the hold/gap counters, stop (pulse) aborts to idle.
// Ports   : clk, rst (async, active high); bus = note_display_sequencer_if.master carrying
//           start/pause/stop, rom_addr/rom_data, code, playing, beat and done.
module note_display_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int SONG_LEN = 32,
    parameter int TICK_DIV = 3000000,
    parameter int GAP_CYC  = 300000,
    parameter int LOOP     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    note_display_sequencer_if.master bus
);
    // Counter widths: enough to hold 0..N-1, never narrower than one bit.
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);
    localparam bit                HAS_GAP  = (GAP_CYC > 0);
    localparam bit                LOOP_EN  = (LOOP != 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [3:0]        code_q;
    logic [1:0]        beats_left;
    logic [PRE_W-1:0]  prescaler;
    logic [GAP_W-1:0]  gap_cnt;

    logic              tick;
    logic              note_over;
    logic              gap_last;
    logic              advance;
    logic              last_note;
    logic              finish;
    logic [ADDR_W-1:0] next_index;

    // A beat tick only exists while HOLD is actually running (not paused).
    assign tick      = (state == S_HOLD) && !bus.pause && (prescaler == PRE_MAX);
    assign note_over = tick && (beats_left == 2'd0);
    assign gap_last  = (state == S_GAP) && !bus.pause && (gap_cnt == GAP_MAX);

    // Leaving a note: straight from HOLD when there is no gap, otherwise at the end of GAP.
    assign advance    = (note_over && !HAS_GAP) || gap_last;
    assign last_note  = (index == LAST_IDX);
    assign finish     = advance && last_note && !LOOP_EN;
    assign next_index = last_note ? '0 : index + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            index      <= '0;
            rom_addr_q <= '0;
            code_q     <= '0;
            beats_left <= '0;
            prescaler  <= '0;
            gap_cnt    <= '0;
        end else if (bus.stop) begin
            // Abort wins over start and pause; no done pulse on this path.
            state      <= S_IDLE;
            index      <= '0;
            rom_addr_q <= '0;
            code_q     <= '0;
            beats_left <= '0;
            prescaler  <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_FETCH;
                        index      <= '0;
                        rom_addr_q <= '0;
                    end
                end
                S_FETCH: begin
                    // rom_addr already carries index; the ROM registers it on this edge.
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    code_q     <= bus.rom_data[5:2];
                    beats_left <= bus.rom_data[1:0];
                    prescaler  <= '0;
                    state      <= S_HOLD;
                end
                S_HOLD: begin
                    if (!bus.pause) begin
                        if (prescaler == PRE_MAX) begin
                            prescaler <= '0;
                            if (beats_left != 2'd0) begin
                                beats_left <= beats_left - 2'd1;
                            end else if (HAS_GAP) begin
                                state   <= S_GAP;
                                code_q  <= '0;
                                gap_cnt <= '0;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (!bus.pause && (gap_cnt != GAP_MAX)) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    state      <= S_IDLE;
                    index      <= '0;
                    rom_addr_q <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Note-to-note step overrides the per-state updates above.
            if (advance) begin
                if (finish) begin
                    state  <= S_FIN;
                    code_q <= '0;
                end else begin
                    state      <= S_FETCH;
                    index      <= next_index;
                    rom_addr_q <= next_index;
                end
            end
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.code     = code_q;
    assign bus.playing  = (state == S_FETCH) || (state == S_LOAD) ||
                          (state == S_HOLD)  || (state == S_GAP);
    assign bus.beat     = tick;
    assign bus.done     = (state == S_FIN);

endmodule
